sram_ctrl: RTL and testbench

- Sequencing controller between the single-cycle core's LSU and the board's external 256K x 16 asynchronous SRAM. Drives SRAM_ADDR, SRAM_DQ, SRAM_CE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N and SRAM_OE_N.
- Converts one 32-bit request into two 16-bit SRAM cycles, low halfword first.
- Uses registered, glitch-free strobes and a programmable access width.
- Reports completion with a one-cycle pulse.

---
 rtl/sram_ctrl_if.sv | 22 ++
 rtl/sram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// LSU-side request/response bus of the external SRAM controller.
// The requester (master) holds i_req until it sees o_ready; o_done pulses once per accepted request.
interface sram_ctrl_if;
    logic        i_req;
    logic        i_we;
    logic [18:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_bmask;
    logic        o_ready;
    logic        o_done;
    logic [31:0] o_rdata;

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_bmask,
        input  o_ready, o_done, o_rdata
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_bmask,
        output o_ready, o_done, o_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// Splits one 32-bit LSU access into two 16-bit asynchronous SRAM cycles, low halfword first.
// Every SRAM pin and the DQ drive enable come straight from flops, so the strobes are glitch-free.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sram_ctrl_if.slave  bus,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_UB_N,
    output logic [2:0]  o_dbg_state
);
    // Handshake: a request transfers on a rising edge where i_req && o_ready; o_ready = (state == IDLE).
    typedef enum logic [2:0] {
        IDLE, LO_SETUP, LO_ACCESS, HI_SETUP, HI_ACCESS, DONE
    } state_e;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        we_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;

    logic [17:0] addr_q, addr_d;
    logic        ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic        lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        req_we;
    logic [16:0] req_word;
    logic [31:0] req_wdata;
    logic [3:0]  req_bmask;
    logic        hi_half;
    logic        unused_addr_lsbs;

    assign accept           = (state_q == IDLE) && bus.i_req;
    assign unused_addr_lsbs = ^bus.i_addr[1:0];

    // Pin values are computed from the next state, so on the accept edge the
    // request fields are not yet in the capture registers and come from the bus.
    always_comb begin
        if (state_q == IDLE) begin
            req_we    = bus.i_we;
            req_word  = bus.i_addr[18:2];
            req_wdata = bus.i_wdata;
            req_bmask = bus.i_bmask;
        end else begin
            req_we    = we_q;
            req_word  = word_q;
            req_wdata = wdata_q;
            req_bmask = bmask_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req) begin
                    if (bus.i_we && bus.i_bmask == 4'h0)           state_d = DONE;
                    else if (bus.i_we && bus.i_bmask[1:0] == 2'b00) state_d = HI_SETUP;
                    else                                            state_d = LO_SETUP;
                end
            end
            LO_SETUP: begin
                state_d = LO_ACCESS;
                cnt_d   = WAIT_LAST;
            end
            LO_ACCESS: begin
                if (cnt_q == 4'd0) state_d = (!we_q || bmask_q[3:2] != 2'b00) ? HI_SETUP : DONE;
                else               cnt_d = cnt_q - 4'd1;
            end
            HI_SETUP: begin
                state_d = HI_ACCESS;
                cnt_d   = WAIT_LAST;
            end
            HI_ACCESS: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d   = '0;
        ce_n_d   = 1'b1;
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = '0;
        done_d   = (state_d == DONE);
        rdata_d  = rdata_q;
        hi_half  = (state_d == HI_SETUP) || (state_d == HI_ACCESS);
        if (state_d inside {LO_SETUP, LO_ACCESS, HI_SETUP, HI_ACCESS}) begin
            addr_d = {req_word, hi_half};
            ce_n_d = 1'b0;
            if (req_we) begin
                we_n_d   = !(state_d == LO_ACCESS || state_d == HI_ACCESS);
                dq_oe_d  = 1'b1;
                dq_out_d = hi_half ? req_wdata[31:16] : req_wdata[15:0];
                lb_n_d   = hi_half ? !req_bmask[2] : !req_bmask[0];
                ub_n_d   = hi_half ? !req_bmask[3] : !req_bmask[1];
            end else begin
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end
        // Read data is taken on the edge that ends the last access cycle of each half.
        if (!we_q && cnt_q == 4'd0) begin
            if (state_q == LO_ACCESS) rdata_d[15:0]  = SRAM_DQ;
            if (state_q == HI_ACCESS) rdata_d[31:16] = SRAM_DQ;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q     <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            bmask_q  <= '0;
            addr_q   <= '0;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.i_we;
                word_q  <= bus.i_addr[18:2];
                wdata_q <= bus.i_wdata;
                bmask_q <= bus.i_bmask;
            end
            addr_q   <= addr_d;
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            lb_n_q   <= lb_n_d;
            ub_n_q   <= ub_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end

    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ     = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_LB_N   = lb_n_q;
    assign SRAM_UB_N   = ub_n_q;
    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_done  = done_q;
    assign bus.o_rdata = rdata_q;
    assign o_dbg_state = state_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a cycle-level expectation queue built from the access rules, an SRAM pin model,
// and directed transactions with hand-computed latencies, addresses and data.
module tb_sram_ctrl;
  localparam int WAIT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if bus_if();
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ce_n, we_n, oe_n, lb_n, ub_n;
  logic [2:0]  dbg_state;

  sram_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus_if),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n), .o_dbg_state(dbg_state)
  );

  // SRAM pin model: drives DQ on a read, stores bytes while CE_N and WE_N are low at an edge.
  logic [15:0] sram_mem [0:1023];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[9:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram_mem[sram_addr[9:0]][7:0]  = sram_dq[7:0];
      if (!ub_n) sram_mem[sram_addr[9:0]][15:8] = sram_dq[15:8];
    end
  end

  typedef struct packed {
    logic [17:0] addr;
    logic ce_n, we_n, oe_n, lb_n, ub_n, done, ready;
    logic chk_dq;
    logic [15:0] dq;
    logic chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_mem [0:1023];
  logic [31:0] rdata_hold;
  int          n_chk = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idle_vec();
    exp_t e;
    e        = '0;
    e.ce_n   = 1'b1; e.we_n = 1'b1; e.oe_n = 1'b1; e.lb_n = 1'b1; e.ub_n = 1'b1;
    e.ready  = 1'b1;
    e.chk_rd = 1'b1;
    e.rdata  = rdata_hold;
    return e;
  endfunction

  // Expected pin activity for one accepted request: per performed half, one setup
  // cycle plus WAIT access cycles, then a single done cycle with idle pins.
  task automatic model_push(input logic we, input logic [18:0] addr, input logic [31:0] wdata,
                            input logic [3:0] bm);
    exp_t        e;
    logic [17:0] ha [2];
    logic [31:0] rd;
    ha[0] = {addr[18:2], 1'b0};
    ha[1] = {addr[18:2], 1'b1};
    rd    = {model_mem[ha[1][9:0]], model_mem[ha[0][9:0]]};
    for (int h = 0; h < 2; h++) begin
      if (!we || bm[2*h +: 2] != 2'b00) begin
        for (int k = 0; k <= WAIT; k++) begin
          e      = '0;
          e.addr = ha[h];
          e.ce_n = 1'b0;
          if (we) begin
            e.we_n   = (k == 0);
            e.oe_n   = 1'b1;
            e.lb_n   = !bm[2*h];
            e.ub_n   = !bm[2*h+1];
            e.chk_dq = 1'b1;
            e.dq     = wdata[16*h +: 16];
            e.chk_rd = 1'b1;
            e.rdata  = rdata_hold;
            if (k == 0 && bm[2*h])   model_mem[ha[h][9:0]][7:0]  = wdata[16*h +: 8];
            if (k == 0 && bm[2*h+1]) model_mem[ha[h][9:0]][15:8] = wdata[16*h+8 +: 8];
          end else begin
            e.we_n = 1'b1;
            e.oe_n = 1'b0;
            e.lb_n = 1'b0;
            e.ub_n = 1'b0;
          end
          exp_q.push_back(e);
        end
      end
    end
    e       = idle_vec();
    e.ready = 1'b0;
    e.done  = 1'b1;
    e.rdata = we ? rdata_hold : rd;
    exp_q.push_back(e);
  endtask

  // Compare process: every cycle, pins/handshake against the head of the queue (or idle).
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = idle_vec();
      check("pins", 32'({sram_addr, ce_n, we_n, oe_n, lb_n, ub_n, bus_if.o_done, bus_if.o_ready}),
                    32'({e.addr, e.ce_n, e.we_n, e.oe_n, e.lb_n, e.ub_n, e.done, e.ready}));
      if (e.chk_dq) check("dq", 32'(sram_dq), 32'(e.dq));
      if (e.chk_rd) check("rdata", bus_if.o_rdata, e.rdata);
      if (e.done) rdata_hold = e.rdata;
    end
  end

  task automatic do_req(input logic we, input logic [18:0] addr, input logic [31:0] wdata,
                        input logic [3:0] bm, output int busy);
    busy = 0;
    @(negedge clk);
    bus_if.i_req   = 1'b1;
    bus_if.i_we    = we;
    bus_if.i_addr  = addr;
    bus_if.i_wdata = wdata;
    bus_if.i_bmask = bm;
    while (!bus_if.o_ready && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    if (busy >= 100) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: got no o_ready expected o_ready within 100 cycles");
      bus_if.i_req = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus_if.i_req   = 1'b0;
      bus_if.i_we    = 1'($urandom_range(0, 1));
      bus_if.i_addr  = 19'($urandom_range(0, 524287));
      bus_if.i_wdata = $urandom;
      bus_if.i_bmask = 4'($urandom_range(0, 15));
      model_push(we, addr, wdata, bm);
    end
  endtask

  // Returns edges from the accept edge to the start of the o_done cycle, plus the
  // address/data seen in the first cycle after accept.
  task automatic wait_done(output int lat, output logic [17:0] a1, output logic [15:0] d1);
    lat = -1;
    a1  = '0;
    d1  = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a1 = sram_addr;
        d1 = sram_dq;
      end
      if (bus_if.o_done) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) $display("FAIL done_timeout: got no o_done expected o_done within 40 cycles");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int          busy, busy2, lat;
    logic [17:0] a1;
    logic [15:0] d1;
    bus_if.i_req   = 1'b0;
    bus_if.i_we    = 1'b0;
    bus_if.i_addr  = '0;
    bus_if.i_wdata = '0;
    bus_if.i_bmask = '0;
    rdata_hold     = '0;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i]  = '0;
      model_mem[i] = '0;
    end

    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", 32'(bus_if.o_ready), 32'd1);
    check("reset_done", 32'(bus_if.o_done), 32'd0);
    check("reset_rdata", bus_if.o_rdata, 32'h0);
    check("reset_addr", 32'(sram_addr), 32'h0);
    check("reset_strobes", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1f);
    @(negedge clk);
    rst = 1'b0;

    // Full write then readback.
    do_req(1'b1, 19'h00010, 32'hDEADBEEF, 4'hF, busy);
    wait_done(lat, a1, d1);
    check("wr_full_lat", 32'(lat), 32'd4);
    check("wr_full_addr", 32'(a1), 32'h8);
    check("wr_full_dq", 32'(d1), 32'hBEEF);
    do_req(1'b0, 19'h00010, 32'h0, 4'h0, busy);
    wait_done(lat, a1, d1);
    check("rd_lat", 32'(lat), 32'd4);
    check("rd_data", bus_if.o_rdata, 32'hDEADBEEF);

    // Byte 2 only: high half alone.
    do_req(1'b1, 19'h00010, 32'h00AB0000, 4'h4, busy);
    wait_done(lat, a1, d1);
    check("wr_part_lat", 32'(lat), 32'd2);
    check("wr_part_addr", 32'(a1), 32'h9);
    check("wr_part_dq", 32'(d1), 32'h00AB);
    check("wr_part_lbub", 32'({lb_n, ub_n}), 32'h3);
    do_req(1'b0, 19'h00010, 32'h0, 4'h0, busy);
    wait_done(lat, a1, d1);
    check("rd_part", bus_if.o_rdata, 32'hDEABBEEF);

    // Mask zero: no strobes, done straight away, read data untouched.
    do_req(1'b1, 19'h00020, 32'h12345678, 4'h0, busy);
    wait_done(lat, a1, d1);
    check("wr_zero_lat", 32'(lat), 32'd0);
    check("wr_zero_rdata", bus_if.o_rdata, 32'hDEABBEEF);
    do_req(1'b0, 19'h00020, 32'h0, 4'h0, busy);
    wait_done(lat, a1, d1);
    check("rd_zero", bus_if.o_rdata, 32'h0);

    // Low half only, then scattered bytes 0 and 3.
    do_req(1'b1, 19'h00040, 32'hCAFEF00D, 4'h3, busy);
    wait_done(lat, a1, d1);
    check("wr_lo_lat", 32'(lat), 32'd2);
    check("wr_lo_addr", 32'(a1), 32'h20);
    check("wr_lo_dq", 32'(d1), 32'hF00D);
    do_req(1'b1, 19'h00043, 32'h11223344, 4'h9, busy);
    wait_done(lat, a1, d1);
    check("wr_9_lat", 32'(lat), 32'd4);
    do_req(1'b0, 19'h00040, 32'h0, 4'h0, busy);
    wait_done(lat, a1, d1);
    check("rd_mix", bus_if.o_rdata, 32'h1100F044);

    // Reset during the low access cycle of a full write.
    do_req(1'b1, 19'h00100, 32'hA5A55A5A, 4'hF, busy);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    rdata_hold = '0;
    model_mem[10'h080] = 16'h5A5A;
    model_mem[10'h081] = 16'h0000;
    @(posedge clk);
    #1;
    check("rst_we_n", 32'(we_n), 32'd1);
    check("rst_done", 32'(bus_if.o_done), 32'd0);
    check("rst_ready", 32'(bus_if.o_ready), 32'd1);
    check("rst_rdata", bus_if.o_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 19'h00100, 32'h0, 4'h0, busy);
    wait_done(lat, a1, d1);
    check("rd_abort", bus_if.o_rdata, 32'h00005A5A);

    // Second request held through the busy window of the first.
    do_req(1'b1, 19'h00200, 32'h01020304, 4'hF, busy);
    check("b2b_first_wait", 32'(busy), 32'd0);
    do_req(1'b0, 19'h00200, 32'h0, 4'h0, busy2);
    check("b2b_second_wait", 32'(busy2), 32'd5);
    wait_done(lat, a1, d1);
    check("b2b_rd_lat", 32'(lat), 32'd4);
    check("b2b_rd_data", bus_if.o_rdata, 32'h01020304);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
